// File: rtl/byte_serial_mem_xfer_if.sv
// ============================================================================
// Module      : byte_serial_mem_xfer_if
// Description : Request, status and byte-wide memory bus of the byte-serial
//               word transfer engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface byte_serial_mem_xfer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              Start;
    logic              Op;
    logic              Endian;
    logic [ADDR_W-1:0] BaseAddr;
    logic [DATA_W-1:0] StoreData;
    logic [7:0]        MemOut;
    logic [ADDR_W-1:0] Mem_Address;
    logic [7:0]        Mem_Data;
    logic              Mem_WR;
    logic              Mem_CS;
    logic              Busy;
    logic              Done;
    logic [DATA_W-1:0] LoadData;

    // Requester plus memory side.
    modport master (
        output Start, Op, Endian, BaseAddr, StoreData, MemOut,
        input  Mem_Address, Mem_Data, Mem_WR, Mem_CS, Busy, Done, LoadData
    );

    // Transfer engine side.
    modport slave (
        input  Start, Op, Endian, BaseAddr, StoreData, MemOut,
        output Mem_Address, Mem_Data, Mem_WR, Mem_CS, Busy, Done, LoadData
    );
endinterface

`default_nettype wire

// File: rtl/byte_serial_mem_xfer.sv
// ============================================================================
// Module      : byte_serial_mem_xfer
// Description : Moves one DATA_W word between a register and a byte-wide
//               memory, one byte per cycle, in either endianness.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_serial_mem_xfer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    byte_serial_mem_xfer_if.slave  bus
);
    localparam int c_NB    = DATA_W / 8;
    localparam int c_IDX_W = (c_NB > 1) ? $clog2(c_NB) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state_q,  state_d;
    logic [c_IDX_W-1:0]   idx_q,    idx_d;
    logic                 op_q,     op_d;
    logic                 endian_q, endian_d;
    logic [ADDR_W-1:0]    base_q,   base_d;
    logic [DATA_W-1:0]    store_q,  store_d;
    logic [DATA_W-1:0]    shadow_q, shadow_d;
    logic [DATA_W-1:0]    load_q,   load_d;

    logic [c_IDX_W-1:0]   w_lane;
    logic                 w_xfer;
    logic [7:0]           w_mem_data;

    // Big-endian walks the lanes from the most significant byte downward.
    assign w_lane = endian_q ? (c_LAST_IDX - idx_q) : idx_q;

    // Reset blanks the strobe in the same cycle so an aborted store cannot
    // write one more byte on the reset edge.
    assign w_xfer = (state_q == XFER) && !rst;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op_d     = op_q;
        endian_d = endian_q;
        base_d   = base_q;
        store_d  = store_q;
        shadow_d = shadow_q;
        load_d   = load_q;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d  = XFER;
                    idx_d    = '0;
                    op_d     = bus.Op;
                    endian_d = bus.Endian;
                    base_d   = bus.BaseAddr;
                    store_d  = bus.StoreData;
                end
            end
            XFER: begin
                if (!op_q) begin
                    for (int b = 0; b < c_NB; b++) begin
                        if (w_lane == c_IDX_W'(b)) begin
                            shadow_d[b*8 +: 8] = bus.MemOut;
                        end
                    end
                end
                if (idx_q == c_LAST_IDX) begin
                    state_d = FIN;
                    idx_d   = '0;
                    // Publish the complete word, including the final byte.
                    if (!op_q) begin
                        load_d = shadow_d;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        w_mem_data = '0;
        if (w_xfer && op_q) begin
            for (int b = 0; b < c_NB; b++) begin
                if (w_lane == c_IDX_W'(b)) begin
                    w_mem_data = store_q[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            op_q     <= 1'b0;
            endian_q <= 1'b0;
            base_q   <= '0;
            store_q  <= '0;
            shadow_q <= '0;
            load_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            endian_q <= endian_d;
            base_q   <= base_d;
            store_q  <= store_d;
            shadow_q <= shadow_d;
            load_q   <= load_d;
        end
    end

    assign bus.Mem_CS      = !w_xfer;
    assign bus.Mem_WR      = w_xfer && op_q;
    assign bus.Mem_Address = w_xfer ? (base_q + ADDR_W'(idx_q)) : '0;
    assign bus.Mem_Data    = w_mem_data;
    assign bus.Busy        = (state_q == XFER);
    assign bus.Done        = (state_q == FIN);
    assign bus.LoadData    = load_q;

endmodule

`default_nettype wire

// File: tb/tb_byte_serial_mem_xfer.sv
// ============================================================================
// Module      : tb_byte_serial_mem_xfer
// Description : Directed bench for 16-bit and 32-bit transfer engines, each
//               attached to its own byte-wide memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_byte_serial_mem_xfer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [7:0] mem16 [0:65535];
    logic [7:0] mem32 [0:65535];

    byte_serial_mem_xfer_if #(.DATA_W(16), .ADDR_W(16)) bus16 ();
    byte_serial_mem_xfer_if #(.DATA_W(32), .ADDR_W(16)) bus32 ();

    byte_serial_mem_xfer #(.DATA_W(16), .ADDR_W(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    byte_serial_mem_xfer #(.DATA_W(32), .ADDR_W(16)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus16.MemOut = mem16[bus16.Mem_Address];
    assign bus32.MemOut = mem32[bus32.Mem_Address];

    always @(posedge clk) begin
        if (bus16.Mem_CS === 1'b0 && bus16.Mem_WR === 1'b1)
            mem16[bus16.Mem_Address] = bus16.Mem_Data;
        if (bus32.Mem_CS === 1'b0 && bus32.Mem_WR === 1'b1)
            mem32[bus32.Mem_Address] = bus32.Mem_Data;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus16.Busy, bus16.Done, bus16.Mem_CS, bus16.Mem_WR, bus16.Mem_Address, bus16.Mem_Data}
            !== {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs16: got busy=%b done=%b cs=%b wr=%b addr=%h data=%h, expected 0 0 1 0 0000 00",
                     bus16.Busy, bus16.Done, bus16.Mem_CS, bus16.Mem_WR, bus16.Mem_Address, bus16.Mem_Data);
        end
        checks++;
        if ({bus32.Busy, bus32.Done, bus32.Mem_CS, bus32.Mem_WR, bus32.Mem_Address, bus32.Mem_Data}
            !== {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs32: got busy=%b done=%b cs=%b wr=%b addr=%h data=%h, expected 0 0 1 0 0000 00",
                     bus32.Busy, bus32.Done, bus32.Mem_CS, bus32.Mem_WR, bus32.Mem_Address, bus32.Mem_Data);
        end
        checks++;
        if (bus16.LoadData !== 16'h0000) begin
            errors++;
            $display("FAIL reset_loaddata16: got %h expected 0000", bus16.LoadData);
        end
        checks++;
        if (bus32.LoadData !== 32'h0) begin
            errors++;
            $display("FAIL reset_loaddata32: got %h expected 00000000", bus32.LoadData);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_le16();
        mem16[16'h0010] = 8'h34;
        mem16[16'h0011] = 8'h12;
        bus16.Op = 1'b0; bus16.Endian = 1'b0; bus16.BaseAddr = 16'h0010; bus16.Start = 1'b1;
        @(negedge clk);
        // Changing the request inputs mid-transfer must have no effect.
        bus16.Start = 1'b0; bus16.Op = 1'b1; bus16.Endian = 1'b1; bus16.BaseAddr = 16'h0055;
        checks++;
        if ({bus16.Busy, bus16.Mem_CS, bus16.Mem_WR, bus16.Mem_Address} !== {1'b1, 1'b0, 1'b0, 16'h0010}) begin
            errors++;
            $display("FAIL le16_xfer0: got busy=%b cs=%b wr=%b addr=%h expected 1 0 0 0010",
                     bus16.Busy, bus16.Mem_CS, bus16.Mem_WR, bus16.Mem_Address);
        end
        @(negedge clk);
        checks++;
        if ({bus16.Busy, bus16.Mem_CS, bus16.Mem_WR, bus16.Mem_Address} !== {1'b1, 1'b0, 1'b0, 16'h0011}) begin
            errors++;
            $display("FAIL le16_xfer1: got busy=%b cs=%b wr=%b addr=%h expected 1 0 0 0011",
                     bus16.Busy, bus16.Mem_CS, bus16.Mem_WR, bus16.Mem_Address);
        end
        @(negedge clk);
        checks++;
        if ({bus16.Done, bus16.Busy, bus16.Mem_CS} !== 3'b101) begin
            errors++;
            $display("FAIL le16_fin: got done=%b busy=%b cs=%b expected 1 0 1",
                     bus16.Done, bus16.Busy, bus16.Mem_CS);
        end
        checks++;
        if (bus16.LoadData !== 16'h1234) begin
            errors++;
            $display("FAIL le16_loaddata: got %h expected 1234", bus16.LoadData);
        end
        @(negedge clk);
        checks++;
        if ({bus16.Done, bus16.Busy} !== 2'b00) begin
            errors++;
            $display("FAIL le16_idle: got done=%b busy=%b expected 0 0", bus16.Done, bus16.Busy);
        end
        bus16.Op = 1'b0; bus16.Endian = 1'b0; bus16.BaseAddr = 16'h0000;
    endtask

    task automatic test_load_be32();
        mem32[16'h0200] = 8'h11; mem32[16'h0201] = 8'h22;
        mem32[16'h0202] = 8'h33; mem32[16'h0203] = 8'h44;
        bus32.Op = 1'b0; bus32.Endian = 1'b1; bus32.BaseAddr = 16'h0200; bus32.Start = 1'b1;
        @(negedge clk);
        bus32.Start = 1'b0;
        checks++;
        if (bus32.Mem_Address !== 16'h0200) begin
            errors++;
            $display("FAIL be32_load_addr0: got %h expected 0200", bus32.Mem_Address);
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({bus32.Done, bus32.LoadData} !== {1'b1, 32'h11223344}) begin
            errors++;
            $display("FAIL be32_load: got done=%b data=%h expected 1 11223344", bus32.Done, bus32.LoadData);
        end
        @(negedge clk);
    endtask

    task automatic test_store_be32();
        logic [7:0] exp_b [4];
        int cs_cnt;
        int done_cnt;
        exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
        cs_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 4; i++) mem32[16'h0100 + 16'(i)] = 8'h00;
        bus32.Op = 1'b1; bus32.Endian = 1'b1; bus32.BaseAddr = 16'h0100;
        bus32.StoreData = 32'hDEADBEEF; bus32.Start = 1'b1;
        @(negedge clk);
        bus32.Start = 1'b0; bus32.StoreData = 32'h0;
        for (int n = 0; n < 8; n++) begin
            if (bus32.Mem_CS === 1'b0) begin
                checks++;
                if (cs_cnt > 3 || {bus32.Mem_WR, bus32.Mem_Data, bus32.Mem_Address}
                    !== {1'b1, exp_b[cs_cnt & 3], 16'h0100 + 16'(cs_cnt)}) begin
                    errors++;
                    $display("FAIL be32_store_byte%0d: got wr=%b data=%h addr=%h expected 1 %h %h",
                             cs_cnt, bus32.Mem_WR, bus32.Mem_Data, bus32.Mem_Address,
                             exp_b[cs_cnt & 3], 16'h0100 + 16'(cs_cnt));
                end
                cs_cnt++;
            end
            if (bus32.Done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        checks++;
        if (cs_cnt != 4) begin
            errors++;
            $display("FAIL be32_store_cs_cycles: got %0d expected 4", cs_cnt);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL be32_store_done_count: got %0d expected 1", done_cnt);
        end
        checks++;
        if ({mem32[16'h0100], mem32[16'h0101], mem32[16'h0102], mem32[16'h0103]} !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL be32_store_mem: got %h%h%h%h expected DEADBEEF",
                     mem32[16'h0100], mem32[16'h0101], mem32[16'h0102], mem32[16'h0103]);
        end
        checks++;
        if (bus32.LoadData !== 32'h11223344) begin
            errors++;
            $display("FAIL be32_store_loaddata: got %h expected 11223344", bus32.LoadData);
        end
    endtask

    task automatic test_wrap16();
        mem16[16'hFFFF] = 8'hAB;
        mem16[16'h0000] = 8'hCD;
        bus16.Op = 1'b0; bus16.Endian = 1'b0; bus16.BaseAddr = 16'hFFFF; bus16.Start = 1'b1;
        @(negedge clk);
        bus16.Start = 1'b0;
        checks++;
        if (bus16.Mem_Address !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_addr0: got %h expected FFFF", bus16.Mem_Address);
        end
        @(negedge clk);
        checks++;
        if ({bus16.Mem_CS, bus16.Mem_Address} !== {1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL wrap_addr1: got cs=%b addr=%h expected 0 0000", bus16.Mem_CS, bus16.Mem_Address);
        end
        @(negedge clk);
        checks++;
        if ({bus16.Done, bus16.LoadData} !== {1'b1, 16'hCDAB}) begin
            errors++;
            $display("FAIL wrap_loaddata: got done=%b data=%h expected 1 CDAB", bus16.Done, bus16.LoadData);
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int done_cnt;
        done_cnt = 0;
        mem16[16'h0020] = 8'h78; mem16[16'h0021] = 8'h56;
        mem16[16'h0030] = 8'h99; mem16[16'h0031] = 8'h88;
        bus16.Op = 1'b0; bus16.Endian = 1'b0; bus16.BaseAddr = 16'h0020; bus16.Start = 1'b1;
        @(negedge clk);
        bus16.Start = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (n == 1) begin
                bus16.Start = 1'b1; bus16.Op = 1'b1;
                bus16.BaseAddr = 16'h0030; bus16.StoreData = 16'hFFFF;
            end
            if (n == 2) bus16.Start = 1'b0;
            if (bus16.Done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d expected 1", done_cnt);
        end
        checks++;
        if ({bus16.Busy, bus16.LoadData} !== {1'b0, 16'h5678}) begin
            errors++;
            $display("FAIL ignore_loaddata: got busy=%b data=%h expected 0 5678", bus16.Busy, bus16.LoadData);
        end
        checks++;
        if ({mem16[16'h0030], mem16[16'h0031]} !== 16'h9988) begin
            errors++;
            $display("FAIL ignore_mem_untouched: got %h%h expected 9988", mem16[16'h0030], mem16[16'h0031]);
        end
        bus16.Op = 1'b0;
    endtask

    task automatic test_reset_abort();
        int done_cnt;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) mem32[16'h0300 + 16'(i)] = 8'h00;
        bus32.Op = 1'b1; bus32.Endian = 1'b0; bus32.BaseAddr = 16'h0300;
        bus32.StoreData = 32'hA1B2C3D4; bus32.Start = 1'b1;
        @(negedge clk);
        bus32.Start = 1'b0;
        repeat (2) begin
            if (bus32.Done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus32.Busy, bus32.Done, bus32.Mem_CS, bus32.Mem_WR, bus32.Mem_Address, bus32.Mem_Data, bus32.LoadData}
            !== {1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 32'h0}) begin
            errors++;
            $display("FAIL abort_reset_outputs: got busy=%b done=%b cs=%b wr=%b addr=%h data=%h load=%h expected 0 0 1 0 0000 00 00000000",
                     bus32.Busy, bus32.Done, bus32.Mem_CS, bus32.Mem_WR, bus32.Mem_Address, bus32.Mem_Data, bus32.LoadData);
        end
        repeat (6) begin
            if (bus32.Done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL abort_done_count: got %0d expected 0", done_cnt);
        end
        checks++;
        if ({mem32[16'h0300], mem32[16'h0301], mem32[16'h0302], mem32[16'h0303]} !== 32'hD4C30000) begin
            errors++;
            $display("FAIL abort_mem: got %h %h %h %h expected D4 C3 00 00",
                     mem32[16'h0300], mem32[16'h0301], mem32[16'h0302], mem32[16'h0303]);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_busy;
        logic exp_done;
        mem16[16'h0040] = 8'h01; mem16[16'h0041] = 8'h02;
        bus16.Op = 1'b0; bus16.Endian = 1'b0; bus16.BaseAddr = 16'h0040; bus16.Start = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            exp_busy = ((n % 4) < 2);
            exp_done = ((n % 4) == 2);
            checks++;
            if ({bus16.Busy, bus16.Done} !== {exp_busy, exp_done}) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got busy=%b done=%b expected %b %b",
                         n, bus16.Busy, bus16.Done, exp_busy, exp_done);
            end
        end
        bus16.Start = 1'b0;
        checks++;
        if (bus16.LoadData !== 16'h0201) begin
            errors++;
            $display("FAIL b2b_loaddata: got %h expected 0201", bus16.LoadData);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus16.Start = 1'b0; bus16.Op = 1'b0; bus16.Endian = 1'b0;
        bus16.BaseAddr = '0; bus16.StoreData = '0;
        bus32.Start = 1'b0; bus32.Op = 1'b0; bus32.Endian = 1'b0;
        bus32.BaseAddr = '0; bus32.StoreData = '0;

        test_reset();
        test_load_le16();
        test_load_be32();
        test_store_be32();
        test_wrap16();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
